// File: rtl/cache_refill_ctrl.sv
// Miss/refill sequencer for the L1 cache: hit handling, victim writeback,
// line refill, tag update and whole-cache invalidation.
module cache_refill_ctrl #(
  parameter int NSET       = 32,
  parameter int NWAY       = 8,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  localparam int IDXW = $clog2(NSET),
  localparam int WAYW = $clog2(NWAY),
  localparam int OFFW = $clog2(LINE_WORDS * 4),
  localparam int CNTW = $clog2(LINE_WORDS),
  localparam int TAGW = ADDR_W - IDXW - OFFW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_hit,
  input  logic [WAYW-1:0]   req_hit_way,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDXW-1:0]   rep_idx,
  output logic [WAYW-1:0]   rep_way,
  output logic              rep_access,
  output logic              rep_invalid,
  output logic              rep_flush,
  input  logic [WAYW-1:0]   rep_victim,
  input  logic              vic_dirty,
  input  logic [TAGW-1:0]   vic_tag,
  output logic              mem_wb_valid,
  input  logic              mem_wb_ready,
  output logic [ADDR_W-1:0] mem_wb_addr,
  output logic              mem_wb_last,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_dvalid,
  output logic [WAYW-1:0]   arr_way,
  output logic [IDXW-1:0]   arr_idx,
  output logic [CNTW-1:0]   arr_word,
  output logic              arr_fill_we,
  output logic              arr_tag_we,
  output logic              arr_tag_clr,
  input  logic              flush_req,
  output logic              flush_done
);

  typedef enum logic [2:0] {
    IDLE, VICTIM, WB, RD_REQ, RD_DATA, UPDATE, RESP, FLUSH
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-OFFW-1:0] line_q, line_d;
  logic [WAYW-1:0]        way_q, way_d;
  logic [TAGW-1:0]        vtag_q, vtag_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [IDXW-1:0]        set_q, set_d;

  logic [IDXW-1:0] idx_s;
  logic            last_beat_s;
  logic            unused_offset_s;

  assign idx_s           = line_q[IDXW-1:0];
  assign last_beat_s     = (cnt_q == CNTW'(LINE_WORDS - 1));
  assign unused_offset_s = ^req_addr[OFFW-1:0];

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      way_q   <= '0;
      vtag_q  <= '0;
      cnt_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      way_q   <= way_d;
      vtag_q  <= vtag_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    way_d        = way_q;
    vtag_d       = vtag_q;
    cnt_d        = cnt_q;
    set_d        = set_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    rep_idx      = '0;
    rep_way      = '0;
    rep_access   = 1'b0;
    rep_invalid  = 1'b0;
    rep_flush    = 1'b0;
    mem_wb_valid = 1'b0;
    mem_wb_addr  = '0;
    mem_wb_last  = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_addr  = '0;
    arr_way      = '0;
    arr_idx      = '0;
    arr_word     = '0;
    arr_fill_we  = 1'b0;
    arr_tag_we   = 1'b0;
    arr_tag_clr  = 1'b0;
    flush_done   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = ~flush_req;
        if (flush_req) begin
          set_d   = '0;
          state_d = FLUSH;
        end else if (req_valid) begin
          line_d = req_addr[ADDR_W-1:OFFW];
          if (req_hit) begin
            rep_access = 1'b1;
            rep_idx    = req_addr[OFFW +: IDXW];
            rep_way    = req_hit_way;
            way_d      = req_hit_way;
            state_d    = RESP;
          end else begin
            state_d = VICTIM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      VICTIM: begin
        rep_idx = idx_s;
        way_d   = rep_victim;
        vtag_d  = vic_tag;
        cnt_d   = '0;
        state_d = vic_dirty ? WB : RD_REQ;
      end
      WB: begin
        mem_wb_valid = 1'b1;
        mem_wb_addr  = {vtag_q, idx_s, OFFW'(0)};
        mem_wb_last  = last_beat_s;
        arr_word     = cnt_q;
        arr_way      = way_q;
        arr_idx      = idx_s;
        if (mem_wb_ready) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = last_beat_s ? RD_REQ : WB;
        end else begin
          cnt_d = cnt_q;
        end
      end
      RD_REQ: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = {line_q, OFFW'(0)};
        if (mem_rd_ready) begin
          cnt_d   = '0;
          state_d = RD_DATA;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_DATA: begin
        arr_fill_we = mem_rd_dvalid;
        arr_word    = cnt_q;
        arr_way     = way_q;
        arr_idx     = idx_s;
        // Counter wraps naturally to 0 after the final beat
        if (mem_rd_dvalid) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = last_beat_s ? UPDATE : RD_DATA;
        end else begin
          cnt_d = cnt_q;
        end
      end
      UPDATE: begin
        arr_tag_we = 1'b1;
        rep_access = 1'b1;
        rep_way    = way_q;
        rep_idx    = idx_s;
        arr_way    = way_q;
        arr_idx    = idx_s;
        state_d    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        arr_way    = way_q;
        arr_idx    = idx_s;
        state_d    = resp_ready ? IDLE : RESP;
      end
      FLUSH: begin
        // Set counter is only zero on the entry cycle
        rep_flush   = (set_q == '0);
        arr_tag_clr = 1'b1;
        arr_idx     = set_q;
        set_d       = set_q + IDXW'(1);
        if (set_q == IDXW'(NSET - 1)) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl.
module tb_cache_refill_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_hit, resp_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_hit_way, rep_victim;
  logic        vic_dirty, mem_wb_ready, mem_rd_ready, mem_rd_dvalid, flush_req;
  logic [22:0] vic_tag;
  logic        req_ready, resp_valid, rep_access, rep_invalid, rep_flush;
  logic [4:0]  rep_idx, arr_idx;
  logic [2:0]  rep_way, arr_way;
  logic        mem_wb_valid, mem_wb_last, mem_rd_valid;
  logic [31:0] mem_wb_addr, mem_rd_addr;
  logic [1:0]  arr_word;
  logic        arr_fill_we, arr_tag_we, arr_tag_clr, flush_done;
  logic [11:0] strb;

  int total = 0;
  int bad   = 0;
  int beat;

  always #5 clock = ~clock;

  // Strobe vector for compact comparisons
  assign strb = {req_ready, resp_valid, rep_access, rep_invalid, rep_flush,
                 mem_wb_valid, mem_wb_last, mem_rd_valid, arr_fill_we,
                 arr_tag_we, arr_tag_clr, flush_done};

  cache_refill_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_hit(req_hit), .req_hit_way(req_hit_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .rep_idx(rep_idx), .rep_way(rep_way), .rep_access(rep_access),
    .rep_invalid(rep_invalid), .rep_flush(rep_flush),
    .rep_victim(rep_victim), .vic_dirty(vic_dirty), .vic_tag(vic_tag),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
    .mem_wb_addr(mem_wb_addr), .mem_wb_last(mem_wb_last),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
    .mem_rd_addr(mem_rd_addr), .mem_rd_dvalid(mem_rd_dvalid),
    .arr_way(arr_way), .arr_idx(arr_idx), .arr_word(arr_word),
    .arr_fill_we(arr_fill_we), .arr_tag_we(arr_tag_we),
    .arr_tag_clr(arr_tag_clr), .flush_req(flush_req), .flush_done(flush_done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_hit = 1'b0; resp_ready = 1'b0;
    req_addr = 32'h0; req_hit_way = 3'd0; rep_victim = 3'd0;
    vic_dirty = 1'b0; vic_tag = 23'h0; mem_wb_ready = 1'b0;
    mem_rd_ready = 1'b0; mem_rd_dvalid = 1'b0; flush_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_strb", 32'(strb), 32'h800);
    chk("reset_wb_addr", mem_wb_addr, 32'h0);

    // Hit: same-cycle replacer access, response next cycle
    req_valid = 1'b1; req_addr = 32'h8000_0010; req_hit = 1'b1; req_hit_way = 3'd5;
    #1;
    chk("hit_strb", 32'(strb), 32'hA00);
    chk("hit_rep_idx", 32'(rep_idx), 32'd1);
    chk("hit_rep_way", 32'(rep_way), 32'd5);
    tick();
    req_valid = 1'b0; req_hit = 1'b0;
    #1;
    chk("hit_resp_strb", 32'(strb), 32'h400);
    chk("hit_resp_way", 32'(arr_way), 32'd5);
    chk("hit_resp_idx", 32'(arr_idx), 32'd1);
    tick();
    chk("hit_resp_hold", 32'(strb), 32'h400);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("hit_back_idle", 32'(strb), 32'h800);

    // Clean miss: idx 18, victim 3
    req_valid = 1'b1; req_addr = 32'h8000_0120;
    #1;
    chk("cm_accept_strb", 32'(strb), 32'h800);
    tick();
    req_valid = 1'b0; rep_victim = 3'd3; vic_dirty = 1'b0;
    #1;
    chk("cm_victim_strb", 32'(strb), 32'h000);
    chk("cm_victim_idx", 32'(rep_idx), 32'd18);
    tick();
    rep_victim = 3'd0;
    chk("cm_rdreq_strb", 32'(strb), 32'h010);
    chk("cm_rd_addr", mem_rd_addr, 32'h8000_0120);
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rd_dvalid = 1'b1;
      #1;
      chk("cm_fill_strb", 32'(strb), 32'h008);
      chk("cm_fill_word", 32'(arr_word), 32'(i));
      chk("cm_fill_way", 32'(arr_way), 32'd3);
      tick();
    end
    mem_rd_dvalid = 1'b0;
    #1;
    chk("cm_update_strb", 32'(strb), 32'h204);
    chk("cm_update_way", 32'(rep_way), 32'd3);
    chk("cm_update_idx", 32'(rep_idx), 32'd18);
    tick();
    chk("cm_resp_strb", 32'(strb), 32'h400);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Dirty miss: idx 2, victim tag 0x400001, toggling writeback ready
    req_valid = 1'b1; req_addr = 32'h1234_5620;
    tick();
    req_valid = 1'b0; rep_victim = 3'd6; vic_dirty = 1'b1; vic_tag = 23'h40_0001;
    #1;
    chk("dm_victim_idx", 32'(rep_idx), 32'd2);
    tick();
    rep_victim = 3'd0; vic_dirty = 1'b0; vic_tag = 23'h0;
    for (int k = 0; k < 8; k++) begin
      mem_wb_ready = k[0];
      beat = k / 2;
      #1;
      chk("dm_wb_strb", 32'(strb), (beat == 3) ? 32'h060 : 32'h040);
      chk("dm_wb_word", 32'(arr_word), 32'(beat));
      chk("dm_wb_addr", mem_wb_addr, 32'h8000_0220);
      tick();
    end
    mem_wb_ready = 1'b0;
    chk("dm_rdreq_strb", 32'(strb), 32'h010);

    // Read request stall, then gapped data beats
    for (int s = 0; s < 5; s++) begin
      chk("stall_rd_strb", 32'(strb), 32'h010);
      chk("stall_rd_addr", mem_rd_addr, 32'h1234_5620);
      tick();
    end
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
    beat = 0;
    for (int c = 0; c < 8; c++) begin
      mem_rd_dvalid = (c == 0 || c == 3 || c == 4 || c == 7);
      #1;
      chk("gap_fill_we", 32'(arr_fill_we), 32'(mem_rd_dvalid));
      chk("gap_fill_word", 32'(arr_word), 32'(beat));
      chk("gap_fill_way", 32'(arr_way), 32'd6);
      if (mem_rd_dvalid) beat = beat + 1;
      tick();
    end
    mem_rd_dvalid = 1'b0;
    chk("gap_fill_count", 32'(beat), 32'd4);
    chk("gap_update_strb", 32'(strb), 32'h204);
    chk("gap_update_way", 32'(rep_way), 32'd6);
    tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Flush wins over a simultaneous request
    flush_req = 1'b1; req_valid = 1'b1; req_hit = 1'b1; req_hit_way = 3'd2;
    req_addr = 32'h0000_0040;
    #1;
    chk("fl_arb_strb", 32'(strb), 32'h000);
    tick();
    flush_req = 1'b0;
    chk("fl_entry_strb", 32'(strb), 32'h082);
    chk("fl_entry_idx", 32'(arr_idx), 32'd0);
    for (int i = 1; i < 32; i++) begin
      tick();
      chk("fl_clr_strb", 32'(strb), (i == 31) ? 32'h003 : 32'h002);
      chk("fl_clr_idx", 32'(arr_idx), 32'(i));
    end
    tick();
    chk("fl_after_strb", 32'(strb), 32'hA00);
    chk("fl_after_idx", 32'(rep_idx), 32'd4);
    chk("fl_after_way", 32'(rep_way), 32'd2);
    tick();
    req_valid = 1'b0; req_hit = 1'b0; resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset during refill data; first beat also shows counter wrapped to 0
    req_valid = 1'b1; req_addr = 32'h0000_0330;
    tick();
    req_valid = 1'b0; rep_victim = 3'd1;
    tick();
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0; mem_rd_dvalid = 1'b1;
    #1;
    chk("rst_fill_word0", 32'(arr_word), 32'd0);
    chk("rst_fill_idx", 32'(arr_idx), 32'd19);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_rd_dvalid = 1'b0;
    #1;
    chk("rst_mid_strb", 32'(strb), 32'h800);
    chk("rst_mid_word", 32'(arr_word), 32'd0);
    chk("rst_mid_rd_addr", mem_rd_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
